// File: rtl/cac_coder_ctrl.sv
// Sequencer/config controller for one FNS CAC coder: feeds words to the registered
// coder, collects its code words into an output FIFO and owns the TSV enable map.
module cac_coder_ctrl #(
  parameter int             DW       = 7,
  parameter int             CW       = 9,
  parameter int             DEPTH    = 4,
  parameter logic [CW-1:0]  RST_FLAG = '1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          cfg_wr,
  input  logic [CW-1:0] cfg_flag,
  output logic          cfg_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code,
  output logic [DW-1:0] coder_datain,
  output logic [CW-1:0] coder_en_flag,
  input  logic [CW-1:0] coder_codeout,
  output logic [15:0]   word_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

  state_t        state, state_nxt;
  logic          pend, pend_nxt;
  logic [CW-1:0] shadow, shadow_nxt, en_nxt;

  // vld_pipe[0]: word sits in coder_datain; vld_pipe[1]: coder_codeout holds its code
  logic [1:0]    vld_pipe;
  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] cnt;
  logic [NW+1:0] occ;
  logic          accept, push, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts every word from acceptance until it leaves the FIFO, so the
  // FIFO cannot overflow even with both pipeline stages full.
  assign occ       = (NW+2)'(vld_pipe[0]) + (NW+2)'(vld_pipe[1]) + (NW+2)'(cnt);
  assign in_ready  = rst_n && (state == RUN) && !pend && (occ < (NW+2)'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = vld_pipe[1];
  assign out_valid = (cnt != '0);
  assign out_code  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign cfg_busy  = pend || (state != RUN);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      coder_datain <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      word_cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) coder_datain <= in_data;
      if (push) begin
        mem[wr_ptr] <= coder_codeout;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        word_cnt <= word_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pend          <= 1'b0;
      shadow        <= RST_FLAG;
      coder_en_flag <= RST_FLAG;
    end else begin
      state         <= state_nxt;
      pend          <= pend_nxt;
      shadow        <= shadow_nxt;
      coder_en_flag <= en_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    shadow_nxt = shadow;
    en_nxt     = coder_en_flag;
    if (cfg_wr) shadow_nxt = cfg_flag;
    case (state)
      RUN: begin
        if (cfg_wr) pend_nxt = 1'b1;
        if (pend) state_nxt = DRAIN;
      end
      DRAIN: begin
        // FIFO entries stay: they were already encoded under the old map.
        if (vld_pipe == 2'b00) state_nxt = APPLY;
      end
      APPLY: begin
        en_nxt    = shadow;
        pend_nxt  = cfg_wr;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_cac_coder_ctrl.sv
// Bench for cac_coder_ctrl: stand-in registered coder, queue-based reference model
// with per-cycle comparison, directed scenarios plus a randomized phase.
module tb_cac_coder_ctrl;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [8:0] cfg_flag = '0;
  logic       cfg_busy;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_code;
  logic [6:0] coder_datain;
  logic [8:0] coder_en_flag;
  logic [8:0] coder_codeout = '0;
  logic [15:0] word_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cac_coder_ctrl #(.DW(7), .CW(9), .DEPTH(DEPTH), .RST_FLAG(9'h1FF)) dut (
    .clock(clock), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_flag(cfg_flag),
    .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .coder_datain(coder_datain), .coder_en_flag(coder_en_flag),
    .coder_codeout(coder_codeout), .word_cnt(word_cnt)
  );

  always #5 clock = ~clock;

  // Stand-in coder: any injective, map-dependent function serves here.
  function automatic logic [8:0] enc(input logic [6:0] d, input logic [8:0] en);
    return ({2'b00, d} * 9'd3) ^ en;
  endfunction

  always @(posedge clock) coder_codeout <= enc(coder_datain, coder_en_flag);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted word is in the queue until popped; it becomes
  // visible two edges after acceptance. A map write starts a busy window that ends
  // one edge after the pipeline has emptied and the drain has lasted >= 2 edges.
  typedef struct { logic [8:0] code; int rdy; } ent_t;
  ent_t       m_q[$];
  int         m_n = 0, m_w = 0, m_L = -100;
  bit         m_seq = 0;
  logic [8:0] m_app = 9'h1FF, m_sh = 9'h1FF;
  logic [15:0] m_wc = 0;
  logic [6:0] m_din = 0;

  always @(posedge clock or negedge rst_n) begin
    bit acc, pp;
    int a;
    if (!rst_n) begin
      m_q.delete();
      m_seq = 0; m_app = 9'h1FF; m_sh = 9'h1FF; m_wc = 0; m_din = 0; m_L = -100;
    end else begin
      m_n++;
      acc = in_valid && !m_seq && (m_q.size() < DEPTH);
      pp  = out_ready && (m_q.size() > 0) && (m_q[0].rdy <= m_n - 1);
      if (pp) begin void'(m_q.pop_front()); m_wc++; end
      if (acc) begin
        m_q.push_back('{enc(in_data, m_app), m_n + 2});
        m_din = in_data;
        m_L = m_n;
      end
      a = (m_w + 3 > m_L + 4) ? m_w + 3 : m_L + 4;
      if (m_seq && m_n == a) begin
        m_app = m_sh;
        if (cfg_wr) begin m_sh = cfg_flag; m_w = m_n; end
        else m_seq = 0;
      end else if (cfg_wr) begin
        m_sh = cfg_flag;
        if (!m_seq) begin m_seq = 1; m_w = m_n; end
      end
    end
  end

  always @(negedge clock) begin
    bit e_ov;
    e_ov = (m_q.size() > 0) && (m_q[0].rdy <= m_n);
    chk("in_ready", in_ready, rst_n && !m_seq && (m_q.size() < DEPTH));
    chk("cfg_busy", cfg_busy, m_seq);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) chk("out_code", out_code, m_q[0].code);
    chk("word_cnt", word_cnt, m_wc);
    chk("coder_en_flag", coder_en_flag, m_app);
    chk("coder_datain", coder_datain, m_din);
  end

  logic [8:0] got[$];
  logic [8:0] lit1 [8] = '{9'h1FF, 9'h1FC, 9'h1F9, 9'h1F6, 9'h1F3, 9'h1F0, 9'h1ED, 9'h1EA};

  initial begin
    int t, sent, acc_t, ov_t, bcnt, nchg;
    bit rdy_all, seen;
    logic [8:0] last_en;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_en_flag", coder_en_flag, 9'h1FF);
    chk("rst_out_code", out_code, 0);
    #2 rst_n = 1'b1;
    @(negedge clock);

    // 1: stream 0..7 at full rate
    out_ready = 1; sent = 0; t = 0; acc_t = -1; ov_t = -1; rdy_all = 1; got.delete();
    while ((sent < 8 || got.size() < 8) && t < 200) begin
      in_valid = (sent < 8); in_data = 7'(sent);
      if (sent < 8 && !in_ready) rdy_all = 0;
      if (out_valid && ov_t < 0) ov_t = t;
      if (out_valid && out_ready) got.push_back(out_code);
      if (in_valid && in_ready) begin if (acc_t < 0) acc_t = t; sent++; end
      @(negedge clock); t++;
    end
    in_valid = 0;
    chk("t1_timeout", t < 200, 1);
    chk("t1_in_ready_held", rdy_all, 1);
    chk("t1_latency", ov_t - acc_t, 3);
    for (int i = 0; i < 8; i++) chk("t1_code", (i < got.size()) ? got[i] : 9'h0, lit1[i]);
    chk("t1_word_cnt", word_cnt, 8);

    // 2: backpressure, 6 offered -> 4 accepted
    out_ready = 0; sent = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (sent < 6); in_data = 7'(8 + sent);
      if (in_valid && in_ready) sent++;
      @(negedge clock);
    end
    chk("t2_accepted", sent, 4);
    out_ready = 1; got.delete(); t = 0;
    while ((got.size() < 6 || sent < 6) && t < 60) begin
      in_valid = (sent < 6); in_data = 7'(8 + sent);
      if (in_valid && in_ready) sent++;
      if (out_valid) got.push_back(out_code);
      @(negedge clock); t++;
    end
    in_valid = 0;
    chk("t2_timeout", t < 60, 1);
    chk("t2_first_code", (got.size() > 0) ? got[0] : 9'h0, 9'h1E7);
    for (int i = 0; i < 6; i++)
      chk("t2_order", (i < got.size()) ? got[i] : 9'h0, enc(7'(8 + i), 9'h1FF));
    chk("t2_word_cnt", word_cnt, 14);

    // 3: map write mid-stream
    sent = 0; bcnt = 0; seen = 0; t = 0;
    while ((sent < 30 || cfg_busy || out_valid) && t < 300) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < 30); in_data = 7'($urandom);
      cfg_wr = (t == 12); cfg_flag = 9'h1EF;
      if (in_valid && in_ready) sent++;
      @(negedge clock); t++;
      if (t == 13) begin
        chk("t3_busy_after_wr", cfg_busy, 1);
        chk("t3_ready_drop", in_ready, 0);
      end
      if (cfg_busy) bcnt++;
    end
    cfg_wr = 0; in_valid = 0;
    chk("t3_timeout", t < 300, 1);
    chk("t3_busy_cycles_ge3", bcnt >= 3, 1);
    chk("t3_en_flag", coder_en_flag, 9'h1EF);

    // 4: two writes, one apply
    cfg_wr = 1; cfg_flag = 9'h0FF; @(negedge clock);
    cfg_wr = 0; @(negedge clock);
    cfg_wr = 1; cfg_flag = 9'h17F; @(negedge clock);
    cfg_wr = 0; nchg = 0; last_en = coder_en_flag; t = 0;
    while (cfg_busy && t < 20) begin
      @(negedge clock); t++;
      if (coder_en_flag != last_en) nchg++;
      last_en = coder_en_flag;
    end
    chk("t4_timeout", t < 20, 1);
    chk("t4_single_apply", nchg, 1);
    chk("t4_en_flag", coder_en_flag, 9'h17F);

    // 5: reset with 2 in flight and 2 buffered
    out_ready = 0; sent = 0; t = 0;
    while (sent < 4 && t < 20) begin
      in_valid = 1; in_data = 7'(40 + sent);
      if (in_ready) sent++;
      @(negedge clock); t++;
    end
    in_valid = 0;
    chk("t5_fill", sent, 4);
    chk("t5_buffered", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_en_flag", coder_en_flag, 9'h1FF);
    chk("t5_word_cnt", word_cnt, 0);
    @(negedge clock); #2 rst_n = 1'b1;
    out_ready = 1; seen = 0;
    repeat (10) begin @(negedge clock); if (out_valid) seen = 1; end
    chk("t5_no_stale", seen, 0);

    // Random traffic with occasional map writes
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 7'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_wr = ($urandom_range(0, 39) == 0);
      cfg_flag = 9'($urandom);
      @(negedge clock);
    end
    cfg_wr = 0; in_valid = 0; out_ready = 1;
    repeat (20) @(negedge clock);

    // 6: word_cnt wrap
    #2 rst_n = 1'b0;
    @(negedge clock); #2 rst_n = 1'b1;
    @(negedge clock);
    sent = 0; t = 0; out_ready = 1;
    while (sent < 65537 && t < 70000) begin
      in_valid = 1; in_data = 7'(sent);
      if (in_ready) sent++;
      @(negedge clock); t++;
    end
    in_valid = 0;
    repeat (10) @(negedge clock);
    chk("t6_timeout", t < 70000, 1);
    chk("t6_word_cnt_wrap", word_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
